gpio_debounce: RTL and testbench

- Input conditioner directly upstream of the Wishbone GPIO controller's input port.
- Synchronizes raw board pins (buttons, switches, PMOD inputs) into i_clk and rejects bounce and glitches with a per-pin stability counter.
- Its clean output drives the controller's GPIO input bus, so the controller's change interrupt fires once per real transition instead of once per bounce.
- Also emits per-pin rise/fall event pulses and an aggregate event strobe.

---
 rtl/gpio_debounce.sv | 83 ++++++++
 tb/tb_gpio_debounce.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_debounce.sv
// Two-flop synchronizer plus per-pin stability-counter debouncer with registered rise/fall/event pulses.
// Latency DEBOUNCE+2 clocks from capture at PRESCALE=1; free-running, no backpressure.
module gpio_debounce #(
  parameter int             NIN      = 16,
  parameter int             CW       = 16,
  parameter int             DEBOUNCE = 1000,
  parameter int             PRESCALE = 1,
  parameter logic [NIN-1:0] DEFAULT  = '0
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic [NIN-1:0] i_pins,
  output logic [NIN-1:0] o_gpio,
  output logic [NIN-1:0] o_rise,
  output logic [NIN-1:0] o_fall,
  output logic           o_event
);

  localparam int            PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE - 1);

  logic [NIN-1:0]         s1;
  logic [NIN-1:0]         s2;
  logic [PW-1:0]          p;
  logic                   tick;
  logic [NIN-1:0][CW-1:0] cnt;
  logic [NIN-1:0][CW-1:0] cnt_nxt;
  logic [NIN-1:0]         gpio_nxt;

  assign tick = (p == P_LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1 <= DEFAULT;
      s2 <= DEFAULT;
    end else begin
      s1 <= i_pins;
      s2 <= s1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)   p <= '0;
    else if (tick) p <= '0;
    else           p <= p + 1'b1;
  end

  // Any matching tick restarts the count, so only DEBOUNCE consecutive mismatches are accepted.
  always_comb begin
    gpio_nxt = o_gpio;
    cnt_nxt  = cnt;
    for (int i = 0; i < NIN; i++) begin
      if (tick) begin
        if (s2[i] == o_gpio[i]) begin
          cnt_nxt[i] = '0;
        end else if (cnt[i] == C_LAST) begin
          gpio_nxt[i] = s2[i];
          cnt_nxt[i]  = '0;
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt     <= '0;
      o_gpio  <= DEFAULT;
      o_rise  <= '0;
      o_fall  <= '0;
      o_event <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      o_gpio  <= gpio_nxt;
      o_rise  <= gpio_nxt & ~o_gpio;
      o_fall  <= ~gpio_nxt & o_gpio;
      o_event <= |(gpio_nxt ^ o_gpio);
    end
  end

endmodule

// File: tb/tb_gpio_debounce.sv
// Directed bench: three debouncer configurations (fast, prescaled, non-zero reset default).
module tb_gpio_debounce;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst_b, rst_c;
  logic [3:0] pins_a, pins_b, pins_c;
  logic [3:0] gpio_a, rise_a, fall_a;
  logic [3:0] gpio_b, rise_b, fall_b;
  logic [3:0] gpio_c, rise_c, fall_c;
  logic       ev_a, ev_b, ev_c;

  int n_cmp = 0;
  int n_err = 0;
  int rise_a_n [4];
  int fall_a_n [4];
  int ev_a_n, rise_b_n, pulse_c_n;

  gpio_debounce #(.NIN(4), .CW(8), .DEBOUNCE(4), .PRESCALE(1), .DEFAULT(4'b0000)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_pins(pins_a),
    .o_gpio(gpio_a), .o_rise(rise_a), .o_fall(fall_a), .o_event(ev_a));

  gpio_debounce #(.NIN(4), .CW(8), .DEBOUNCE(3), .PRESCALE(5), .DEFAULT(4'b0000)) dut_b (
    .i_clk(clk), .i_reset(rst_b), .i_pins(pins_b),
    .o_gpio(gpio_b), .o_rise(rise_b), .o_fall(fall_b), .o_event(ev_b));

  gpio_debounce #(.NIN(4), .CW(8), .DEBOUNCE(4), .PRESCALE(1), .DEFAULT(4'b0100)) dut_c (
    .i_clk(clk), .i_reset(rst_c), .i_pins(pins_c),
    .o_gpio(gpio_c), .o_rise(rise_c), .o_fall(fall_c), .o_event(ev_c));

  task automatic clr();
    for (int i = 0; i < 4; i++) begin
      rise_a_n[i] = 0;
      fall_a_n[i] = 0;
    end
    ev_a_n    = 0;
    rise_b_n  = 0;
    pulse_c_n = 0;
  endtask

  // Advance one clock, sample 1 time unit after the edge and tally pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      rise_a_n[i] += (rise_a[i] === 1'b1) ? 1 : 0;
      fall_a_n[i] += (fall_a[i] === 1'b1) ? 1 : 0;
    end
    ev_a_n    += (ev_a === 1'b1) ? 1 : 0;
    rise_b_n  += (|rise_b) ? 1 : 0;
    pulse_c_n += (|{rise_c, fall_c, ev_c}) ? 1 : 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    pins_a = 4'b0000; pins_b = 4'b0000; pins_c = 4'b0100;
    clr();
    #1;
    rst = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    #1;
    chk("reset_gpio_a", 32'(gpio_a), 32'h0);
    chk("reset_rise_a", 32'(rise_a), 32'h0);
    chk("reset_fall_a", 32'(fall_a), 32'h0);
    chk("reset_event_a", 32'(ev_a), 32'h0);
    chk("reset_gpio_b", 32'(gpio_b), 32'h0);
    chk("reset_gpio_c", 32'(gpio_c), 32'h4);
    tick(); tick();
    rst = 1'b0; rst_c = 1'b0;
    tick(); tick();

    // Clean step on pin 0: captured at edge 1, o_gpio changes at edge 6.
    clr();
    pins_a = 4'b0001;
    repeat (5) tick();
    chk("step_gpio_before", 32'(gpio_a), 32'h0);
    tick();
    chk("step_gpio", 32'(gpio_a), 32'h1);
    chk("step_rise", 32'(rise_a), 32'h1);
    chk("step_event", 32'(ev_a), 32'h1);
    chk("step_fall", 32'(fall_a), 32'h0);
    tick();
    chk("step_rise_end", 32'(rise_a), 32'h0);
    chk("step_event_end", 32'(ev_a), 32'h0);
    chk("step_rise_count", 32'(rise_a_n[0]), 32'd1);
    chk("step_fall_count", 32'(fall_a_n[0]), 32'd0);
    pins_a = 4'b0000;
    repeat (8) tick();
    chk("step_back_low", 32'(gpio_a), 32'h0);
    chk("step_back_fall", 32'(fall_a_n[0]), 32'd1);

    // Glitch of DEBOUNCE-1 clocks on pin 0 is rejected.
    clr();
    pins_a = 4'b0001;
    repeat (3) tick();
    pins_a = 4'b0000;
    repeat (10) tick();
    chk("glitch_gpio", 32'(gpio_a), 32'h0);
    chk("glitch_events", 32'(ev_a_n), 32'd0);

    // Glitch, one matching clock, then hold: full latency again from the re-rise.
    pins_a = 4'b0001;
    repeat (3) tick();
    pins_a = 4'b0000;
    tick();
    pins_a = 4'b0001;
    repeat (5) tick();
    chk("restart_gpio_before", 32'(gpio_a), 32'h0);
    tick();
    chk("restart_gpio", 32'(gpio_a), 32'h1);
    chk("restart_rise", 32'(rise_a), 32'h1);
    pins_a = 4'b0000;
    repeat (8) tick();

    // Bounce on pin 1, toggling every 2 clocks, then a stable high.
    clr();
    for (int k = 0; k < 20; k++) begin
      pins_a[1] = (((k / 2) % 2) == 0);
      tick();
    end
    pins_a[1] = 1'b1;
    repeat (5) tick();
    chk("bounce_gpio_before", 32'(gpio_a[1]), 32'h0);
    tick();
    chk("bounce_gpio", 32'(gpio_a[1]), 32'h1);
    chk("bounce_rise", 32'(rise_a), 32'h2);
    tick();
    chk("bounce_rise_count", 32'(rise_a_n[1]), 32'd1);
    chk("bounce_fall_count", 32'(fall_a_n[1]), 32'd0);
    pins_a = 4'b0000;
    repeat (8) tick();

    // Two pins change on the same clock: one event pulse.
    clr();
    pins_a = 4'b1010;
    repeat (5) tick();
    chk("simul_gpio_before", 32'(gpio_a), 32'h0);
    tick();
    chk("simul_rise", 32'(rise_a), 32'hA);
    chk("simul_event", 32'(ev_a), 32'h1);
    tick();
    chk("simul_event_count", 32'(ev_a_n), 32'd1);
    clr();
    pins_a = 4'b0000;
    repeat (6) tick();
    chk("simul_fall", 32'(fall_a), 32'hA);
    tick();
    chk("simul_fall_events", 32'(ev_a_n), 32'd1);
    chk("simul_gpio_low", 32'(gpio_a), 32'h0);

    // Prescaled instance: ticks land on release-relative edges 5, 10, 15, 20.
    clr();
    rst_b = 1'b0;
    repeat (3) tick();
    pins_b = 4'b0100;
    repeat (16) tick();
    chk("ps_gpio_before", 32'(gpio_b), 32'h0);
    tick();
    chk("ps_gpio", 32'(gpio_b), 32'h4);
    chk("ps_rise", 32'(rise_b), 32'h4);
    pins_b = 4'b1100;
    repeat (9) tick();
    pins_b = 4'b0100;
    repeat (20) tick();
    chk("ps_glitch_gpio", 32'(gpio_b), 32'h4);
    chk("ps_rise_count", 32'(rise_b_n), 32'd1);

    // Asynchronous reset mid-count on an instance with a non-zero default.
    pins_c = 4'b0000;
    repeat (8) tick();
    chk("c_low", 32'(gpio_c), 32'h0);
    pins_c = 4'b0001;
    repeat (4) tick();
    chk("c_midcount", 32'(gpio_c), 32'h0);
    #2;
    rst_c = 1'b1;
    #1;
    chk("c_async_gpio", 32'(gpio_c), 32'h4);
    chk("c_async_rise", 32'(rise_c), 32'h0);
    chk("c_async_fall", 32'(fall_c), 32'h0);
    chk("c_async_event", 32'(ev_c), 32'h0);
    pins_c = 4'b0100;
    tick(); tick();
    rst_c = 1'b0;
    clr();
    repeat (10) tick();
    chk("c_release_pulses", 32'(pulse_c_n), 32'd0);
    chk("c_release_gpio", 32'(gpio_c), 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
